// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial link constants: FSM states, default divider, baud mode codes
//
// Purpose : constants and one helper shared by the serial transmit and receive paths.
// Contents: state_t     - transmitter frame state encoding
//           DEF_BIT_DIV - clocks per bit at 38400 baud from 50 MHz
//           MODE_*      - 2-bit baud select codes, common to TX and RX
//           bit_period  - clocks per bit for a given divider and mode
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int DEF_BIT_DIV = 1302;

    localparam logic [1:0] MODE_38400 = 2'd0;
    localparam logic [1:0] MODE_19200 = 2'd1;
    localparam logic [1:0] MODE_9600  = 2'd2;
    localparam logic [1:0] MODE_4800  = 2'd3;

    // Each mode step halves the baud rate, so the period doubles.
    function automatic int unsigned bit_period(input int unsigned div, input logic [1:0] mode);
        return div << mode;
    endfunction

endpackage

// File: rtl/serial_tx_tick.sv
// rtl/serial_tx_tick.sv - enable-gated bit-period counter emitting a one-clock end-of-bit pulse
//
// Purpose : counts 0..period-1 while enabled and pulses tick on the last count.
// Ports   : clk    - system clock, rising edge
//           rst_n  - asynchronous active-low reset
//           en     - count enable (frame in progress)
//           clear  - synchronous restart of the count at 0; wins over en
//           period - bit period in clocks (>= 2)
//           tick   - high for the single clock where count == period-1
module serial_tx_tick #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clear,
    input  logic [CW-1:0] period,
    output logic          tick
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == (period - ONE));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            // Wrap on the last count so the next bit starts at 0 without a gap.
            cnt_d = tick ? '0 : (cnt_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - UART transmitter: 8N1/8N2 LSB-first frames from a valid/ready byte input
//
// Purpose : accepts one byte per dvalid/dready handshake and serialises it on txd as
//           start bit (0), d0..d7, STOP_BITS stop bits (1). Bit period is BIT_DIV << mode,
//           with mode captured at accept and held for the whole frame.
// Ports   : clk    - system clock, rising edge
//           rst_n  - asynchronous active-low reset
//           mode   - baud select, 0..3 = 38400/19200/9600/4800 at 50 MHz
//           din    - byte to send
//           dvalid - din is valid
//           dready - block can accept a byte this cycle (registered)
//           txd    - serial output, idles high (registered)
//           busy   - frame in progress (registered)
module serial_tx
    import serial_pkg::*;
#(
    parameter int BIT_DIV   = DEF_BIT_DIV,
    parameter int STOP_BITS = 1,
    parameter int CW        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [7:0] din,
    input  logic       dvalid,
    output logic       dready,
    output logic       txd,
    output logic       busy
);

    // The stop counter is one bit wide; with two stop bits the second one is index 1.
    localparam logic LAST_STOP = (STOP_BITS == 2);

    state_t        state_q, state_d;
    logic    [7:0] shreg_q, shreg_d;
    logic    [2:0] bit_idx_q, bit_idx_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic    [1:0] mode_q, mode_d;
    logic          txd_q, txd_d;
    logic          dready_q, dready_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          tick;
    logic [CW-1:0] period;

    // dready_q is low for the first cycle after reset, so a byte presented then is ignored.
    assign accept = (state_q == ST_IDLE) && dready_q && dvalid;
    assign period = CW'(bit_period(BIT_DIV, mode_q));

    serial_tx_tick #(
        .CW(CW)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q != ST_IDLE),
        .clear  (accept),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        mode_d     = mode_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d    = din;
                    mode_d     = mode;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        stop_cnt_d = 1'b0;
                        state_d    = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it;
        // this puts the start bit in the cycle right after the accept edge.
        txd_d    = 1'b1;
        dready_d = 1'b0;
        busy_d   = 1'b1;
        unique case (state_d)
            ST_IDLE: begin
                dready_d = 1'b1;
                busy_d   = 1'b0;
            end
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shreg_d[0];
            ST_STOP:  txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            mode_q     <= MODE_38400;
            txd_q      <= 1'b1;
            dready_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            mode_q     <= mode_d;
            txd_q      <= txd_d;
            dready_q   <= dready_d;
            busy_q     <= busy_d;
        end
    end

    assign txd    = txd_q;
    assign dready = dready_q;
    assign busy   = busy_q;

endmodule
